packet_gen: RTL and testbench

AXI-Stream packet generator. It is the transmit-side source for the 100GbE loopback test. It produces a deterministic, self-describing counting pattern on axis_tx. The downstream packet checker compares the looped-back stream against a tapped copy of that transmit stream. Packet count, packet length and inter-packet gap are programmable; packets_sent reports progress.

---
 rtl/packet_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_packet_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_gen.sv
// packet_gen: programmable AXI-Stream counting-pattern packet source; PACKET_GEN_ERRINJ_EN adds inject_error.
// Latency: first beat valid one cycle after an accepted start; every output is driven from a flop.
// Backpressure: a presented beat is held stable until axis_tx_tready; tvalid never depends on tready.
module packet_gen #(
  parameter int DW    = 512,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      packet_count,
  input  logic [LEN_W-1:0] packet_bytes,
  input  logic [7:0]       gap_cycles,
`ifdef PACKET_GEN_ERRINJ_EN
  input  logic             inject_error,
`endif
  output logic             busy,
  output logic [31:0]      packets_sent,
  output logic [DW-1:0]    axis_tx_tdata,
  output logic [DW/8-1:0]  axis_tx_tkeep,
  output logic [1:0]       axis_tx_tuser,
  output logic             axis_tx_tlast,
  output logic             axis_tx_tvalid,
  input  logic             axis_tx_tready
);

  localparam int BPB   = DW / 8;
  localparam int LANES = DW / 32;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(64);
  localparam logic [LEN_W-1:0] BPB_L   = LEN_W'(BPB);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic             busy_d;
  logic [31:0]      sent_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       gap_q, gap_d;
  logic [7:0]       gctr_q, gctr_d;
  logic             stop_q, stop_d;
  logic [31:0]      wc_q, wc_d;
  logic [LEN_W-1:0] bl_q, bl_d;
  logic [DW-1:0]    tdata_d;
  logic [BPB-1:0]   tkeep_d;
  logic             tlast_d;
  logic             tvalid_d;

  logic             load;
  logic [31:0]      ld_wc;
  logic [LEN_W-1:0] ld_bl;
  logic             hs;
  logic             end_run;
  logic [LEN_W-1:0] len_clamp;

`ifdef PACKET_GEN_ERRINJ_EN
  logic             err_q, err_d;
`endif

  // A beat is fully described by its first word counter and the bytes still owed in the packet.
  function automatic logic [BPB-1:0] beat_keep(input logic [LEN_W-1:0] bl);
    logic [BPB-1:0] k;
    for (int j = 0; j < BPB; j++) begin
      k[j] = (32'(bl) > 32'(j));
    end
    return k;
  endfunction

  function automatic logic [DW-1:0] beat_data(input logic [31:0] wc, input logic [BPB-1:0] keep);
    logic [DW-1:0] d;
    for (int k = 0; k < LANES; k++) begin
      d[32*k +: 32] = wc + 32'(k);
    end
    for (int j = 0; j < BPB; j++) begin
      if (!keep[j]) d[8*j +: 8] = 8'h00;
    end
    return d;
  endfunction

  function automatic logic beat_last(input logic [LEN_W-1:0] bl);
    return (32'(bl) <= 32'(BPB));
  endfunction

  always_comb begin
    state_d   = state_q;
    busy_d    = busy;
    sent_d    = packets_sent;
    cnt_d     = cnt_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gctr_d    = gctr_q;
    stop_d    = stop_q;
    wc_d      = wc_q;
    bl_d      = bl_q;
    tdata_d   = axis_tx_tdata;
    tkeep_d   = axis_tx_tkeep;
    tlast_d   = axis_tx_tlast;
    tvalid_d  = axis_tx_tvalid;
    load      = 1'b0;
    ld_wc     = wc_q;
    ld_bl     = len_q;
    hs        = axis_tx_tvalid & axis_tx_tready;
    end_run   = stop_q | stop | ((cnt_q != 32'd0) && (packets_sent + 32'd1 == cnt_q));
    len_clamp = (packet_bytes < MIN_LEN) ? MIN_LEN : packet_bytes;
`ifdef PACKET_GEN_ERRINJ_EN
    err_d     = err_q | inject_error;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          busy_d  = 1'b1;
          sent_d  = 32'd0;
          stop_d  = 1'b0;
          cnt_d   = packet_count;
          len_d   = len_clamp;
          gap_d   = gap_cycles;
          load    = 1'b1;
          ld_wc   = 32'd0;
          ld_bl   = len_clamp;
        end
      end

      ST_SEND: begin
        stop_d = stop_q | stop;
        if (hs) begin
          if (!axis_tx_tlast) begin
            load  = 1'b1;
            ld_wc = wc_q + 32'(LANES);
            ld_bl = bl_q - BPB_L;
          end else begin
            sent_d = packets_sent + 32'd1;
            if (end_run) begin
              state_d  = ST_IDLE;
              busy_d   = 1'b0;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = '0;
              tkeep_d  = '0;
            end else if (gap_q == 8'd0) begin
              load  = 1'b1;
              ld_wc = wc_q + 32'(LANES);
              ld_bl = len_q;
            end else begin
              // Park the next packet's cursor so the gap exit only has to present it.
              state_d  = ST_GAP;
              gctr_d   = gap_q;
              wc_d     = wc_q + 32'(LANES);
              bl_d     = len_q;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = '0;
              tkeep_d  = '0;
            end
          end
        end
      end

      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (gctr_q <= 8'd1) begin
          state_d = ST_SEND;
          load    = 1'b1;
          ld_wc   = wc_q;
          ld_bl   = bl_q;
        end else begin
          gctr_d = gctr_q - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      wc_d     = ld_wc;
      bl_d     = ld_bl;
      tvalid_d = 1'b1;
      tkeep_d  = beat_keep(ld_bl);
      tdata_d  = beat_data(ld_wc, tkeep_d);
      tlast_d  = beat_last(ld_bl);
`ifdef PACKET_GEN_ERRINJ_EN
      // Corrupt the beat as it is loaded so a presented beat never changes under backpressure.
      if (err_d) begin
        tdata_d[0] = ~tdata_d[0];
        err_d      = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      busy           <= 1'b0;
      packets_sent   <= 32'd0;
      cnt_q          <= 32'd0;
      len_q          <= '0;
      gap_q          <= 8'd0;
      gctr_q         <= 8'd0;
      stop_q         <= 1'b0;
      wc_q           <= 32'd0;
      bl_q           <= '0;
      axis_tx_tdata  <= '0;
      axis_tx_tkeep  <= '0;
      axis_tx_tlast  <= 1'b0;
      axis_tx_tvalid <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy           <= busy_d;
      packets_sent   <= sent_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      gap_q          <= gap_d;
      gctr_q         <= gctr_d;
      stop_q         <= stop_d;
      wc_q           <= wc_d;
      bl_q           <= bl_d;
      axis_tx_tdata  <= tdata_d;
      axis_tx_tkeep  <= tkeep_d;
      axis_tx_tlast  <= tlast_d;
      axis_tx_tvalid <= tvalid_d;
    end
  end

`ifdef PACKET_GEN_ERRINJ_EN
  always_ff @(posedge clk) begin
    if (!resetn) err_q <= 1'b0;
    else         err_q <= err_d;
  end
`endif

  assign axis_tx_tuser = 2'b00;

endmodule

// File: tb/tb_packet_gen.sv
// tb_packet_gen: directed + randomized runs of packet_gen (DW=512) against a queue-based beat model.
module tb_packet_gen;
  logic         clk = 1'b0;
  logic         resetn, start, stop;
  logic [31:0]  packet_count;
  logic [15:0]  packet_bytes;
  logic [7:0]   gap_cycles;
  logic         busy;
  logic [31:0]  packets_sent;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic [1:0]   tuser;
  logic         tlast, tvalid, tready;
`ifdef PACKET_GEN_ERRINJ_EN
  logic         inject_error;
`endif

  always #5 clk = ~clk;

  packet_gen #(.DW(512), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .packet_count(packet_count), .packet_bytes(packet_bytes), .gap_cycles(gap_cycles),
`ifdef PACKET_GEN_ERRINJ_EN
    .inject_error(inject_error),
`endif
    .busy(busy), .packets_sent(packets_sent),
    .axis_tx_tdata(tdata), .axis_tx_tkeep(tkeep), .axis_tx_tuser(tuser),
    .axis_tx_tlast(tlast), .axis_tx_tvalid(tvalid), .axis_tx_tready(tready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [511:0] d; logic [63:0] k; logic l; } beat_t;
  beat_t expq[$];

  // Expected stream for one run: byte-level pattern straight from the packet rules.
  task automatic push_run(input int npk, input int len);
    int L, nb, rem;
    logic [31:0] w;
    beat_t b;
    L   = (len < 64) ? 64 : len;
    nb  = (L + 63) / 64;
    rem = L % 64;
    w   = 32'd0;
    for (int p = 0; p < npk; p++) begin
      for (int i = 0; i < nb; i++) begin
        b.l = (i == nb - 1);
        b.k = (b.l && rem != 0) ? ((64'd1 << rem) - 64'd1) : {64{1'b1}};
        for (int k = 0; k < 16; k++) b.d[32*k +: 32] = w + 32'(k);
        for (int j = 0; j < 64; j++) if (!b.k[j]) b.d[8*j +: 8] = 8'h00;
        expq.push_back(b);
        w = w + 32'd16;
      end
    end
  endtask

  logic         mon_en = 1'b0;
  logic         allow_flip = 1'b0;
  int           flips = 0;
  int           beats = 0;
  int           exp_gap = 0;
  int           idle_run = 0;
  logic         in_gap = 1'b0;
  logic         hold_prev = 1'b0;
  logic [511:0] hold_d;
  logic [63:0]  hold_k;
  logic         hold_l;

  always @(negedge clk) begin
    beat_t e;
    logic [511:0] d;
    if (!mon_en) begin
      hold_prev = 1'b0;
      in_gap    = 1'b0;
    end else begin
      if (hold_prev) chk("hold_stable", {tvalid, tlast, tkeep, tdata}, {1'b1, hold_l, hold_k, hold_d});
      hold_prev = tvalid && !tready;
      hold_d = tdata; hold_k = tkeep; hold_l = tlast;
      if (in_gap) begin
        if (!busy) in_gap = 1'b0;
        else if (tvalid) begin
          chk("gap_len", idle_run, exp_gap);
          in_gap = 1'b0;
        end else idle_run++;
      end
      if (tvalid && tready) begin
        chk("beat_expected", expq.size() != 0, 1'b1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          d = tdata;
          if (allow_flip && ((tdata ^ e.d) == 512'd1)) begin
            flips++;
            d = tdata ^ 512'd1;
          end
          chk("tdata", d, e.d);
          chk("tkeep", tkeep, e.k);
          chk("tlast", tlast, e.l);
        end
        beats++;
        if (tlast) begin
          in_gap   = 1'b1;
          idle_run = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit rnd);
    int n = 0;
    while (busy && n < 3000) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
      n++;
    end
    tready = 1'b1;
    chk("run_done", busy, 1'b0);
  endtask

  task automatic wait_sent(input int target);
    int n = 0;
    while (packets_sent != 32'(target) && n < 3000) begin
      cyc();
      n++;
    end
    chk("sent_reach", packets_sent, target);
  endtask

  task automatic do_run(input int cnt, input int len, input int gap, input bit rnd);
    packet_count = cnt; packet_bytes = 16'(len); gap_cycles = 8'(gap);
    exp_gap = gap;
    push_run(cnt, len);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("first_valid", {busy, tvalid}, 2'b11);
    wait_idle(rnd);
    chk("packets_sent", packets_sent, cnt);
    chk("all_beats", expq.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; tready = 1'b1;
    packet_count = 0; packet_bytes = 0; gap_cycles = 0;
`ifdef PACKET_GEN_ERRINJ_EN
    inject_error = 1'b0;
`endif
    repeat (3) cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_sent", packets_sent, 0);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tuser", tuser, 0);
    resetn = 1'b1;
    cyc();
    mon_en = 1'b1;

    // Back-to-back 128-byte packets, no gap.
    beats = 0;
    do_run(3, 128, 0, 1'b0);
    chk("beats_3x128", beats, 6);

    // Partial last beat, then clamp of a short length.
    do_run(1, 100, 0, 1'b0);
    beats = 0;
    do_run(1, 10, 0, 1'b0);
    chk("beats_clamped", beats, 1);

    // Fixed gap under random backpressure.
    do_run(2, 200, 5, 1'b1);

    // Randomized runs.
    for (int i = 0; i < 5; i++) begin
      do_run($urandom_range(1, 3), $urandom_range(1, 300), $urandom_range(0, 3), 1'b1);
    end

    // Infinite run ended by stop during packet 3; start while busy must be ignored.
    packet_count = 0; packet_bytes = 256; gap_cycles = 0; exp_gap = 0;
    push_run(3, 256);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    packet_bytes = 64;
    start = 1'b1; cyc(); start = 1'b0;
    wait_sent(2);
    stop = 1'b1; cyc(); stop = 1'b0;
    wait_idle(1'b0);
    chk("stop_sent", packets_sent, 3);
    chk("stop_all_beats", expq.size(), 0);

    // Stop during the gap ends the run on the next edge.
    packet_count = 0; packet_bytes = 64; gap_cycles = 10; exp_gap = 10;
    push_run(1, 64);
    start = 1'b1; cyc(); start = 1'b0;
    wait_sent(1);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("gap_stop_busy", busy, 1'b0);
    chk("gap_stop_tvalid", tvalid, 1'b0);
    chk("gap_stop_sent", packets_sent, 1);

`ifdef PACKET_GEN_ERRINJ_EN
    // Two pulses while stalled merge into a single corrupted beat.
    packet_count = 4; packet_bytes = 128; gap_cycles = 1; exp_gap = 1;
    push_run(4, 128);
    allow_flip = 1'b1; flips = 0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    tready = 1'b0;
    inject_error = 1'b1; cyc(); inject_error = 1'b0; cyc();
    inject_error = 1'b1; cyc(); inject_error = 1'b0;
    wait_idle(1'b0);
    chk("err_flips", flips, 1);
    chk("err_sent", packets_sent, 4);
    allow_flip = 1'b0;
`endif

    // Reset while a beat is stalled.
    packet_count = 3; packet_bytes = 128; gap_cycles = 0; exp_gap = 0;
    push_run(3, 128);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    tready = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_rst_sent", packets_sent, 1);
    chk("pre_rst_tvalid", tvalid, 1'b1);
    mon_en = 1'b0;
    resetn = 1'b0;
    cyc();
    chk("mid_rst_tvalid", tvalid, 1'b0);
    chk("mid_rst_sent", packets_sent, 0);
    chk("mid_rst_busy", busy, 1'b0);
    resetn = 1'b1;
    tready = 1'b1;
    expq.delete();
    cyc(); cyc();
    chk("post_rst_tvalid", tvalid, 1'b0);
    mon_en = 1'b1;
    do_run(1, 64, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
